// File: rtl/nn_pkg.sv
// nn_pkg: shared widths and output-width rule for the neuron layer
package nn_pkg;
    localparam int DEF_NEURON_WIDTH = 10;
    localparam int DEF_NEURON_BITS  = 15;
    localparam int DEF_B_BITS       = 15;
    localparam int WEIGHT_W         = 32;
    localparam int ACC_W            = 64;

    function automatic int out_width(input int neuron_bits);
        return neuron_bits + 9;
    endfunction
endpackage

// File: rtl/neuron_input_layer_counter.sv
// counter: step counter that walks 0..END_COUNTER and parks there with a done status
module counter #(
    parameter int END_COUNTER = 9
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] counter_out,
    output logic        counter_donestatus
);
    logic [31:0] next;

    // advance by one until the end index, then hold
    always_comb next = (counter_out == 32'(END_COUNTER)) ? counter_out : counter_out + 32'd1;

    // status is registered alongside the count so both change on the same edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            counter_out        <= '0;
            counter_donestatus <= 1'b0;
        end else begin
            counter_out        <= next;
            counter_donestatus <= (next == 32'(END_COUNTER));
        end
    end
endmodule

// File: rtl/neuron_input_layer.sv
// neuron_input_layer: sequential MAC over the inputs, bias add, optional ReLU, saturating output
module neuron_input_layer
    import nn_pkg::*;
#(
    parameter int NEURON_WIDTH = DEF_NEURON_WIDTH,
    parameter int NEURON_BITS  = DEF_NEURON_BITS,
    parameter int COUNTER_END  = NEURON_WIDTH - 1,
    parameter int B_BITS       = DEF_B_BITS
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   activation_function,
    input  logic signed [WEIGHT_W-1:0]             weights [0:NEURON_WIDTH],
    input  logic signed [NEURON_BITS:0]            data_in [0:NEURON_WIDTH],
    input  logic signed [B_BITS:0]                 b,
    input  logic [31:0]                            counter,
    output logic signed [out_width(NEURON_BITS)-1:0] data_out
);
    localparam int IDX_W = $clog2(NEURON_WIDTH + 1);
    localparam int OUT_W = out_width(NEURON_BITS);
    localparam logic signed [ACC_W-1:0] MAX_OUT = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_OUT = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc, prod, sum, act_sum;
    logic [OUT_W-1:0]        sat;
    logic [IDX_W-1:0]        idx;
    logic                    in_range, last, done;

    // product for the current index, then bias, activation and clamp of the finished sum
    always_comb begin
        in_range = counter <= 32'(COUNTER_END);
        idx      = in_range ? counter[IDX_W-1:0] : '0;
        prod     = in_range ? ACC_W'(data_in[idx]) * ACC_W'(weights[idx]) : '0;
        sum      = acc + ACC_W'(b);
        act_sum  = (activation_function && sum < 0) ? '0 : sum;
        sat      = act_sum > MAX_OUT ? MAX_OUT[OUT_W-1:0] :
                   act_sum < MIN_OUT ? MIN_OUT[OUT_W-1:0] : act_sum[OUT_W-1:0];
    end

    // accumulate up to the last index, then latch the result once and freeze
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc      <= '0;
            last     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else if (!done) begin
            if (last) begin
                done     <= 1'b1;
                data_out <= sat;
            end else if (in_range) begin
                acc  <= acc + prod;
                last <= (counter == 32'(COUNTER_END));
            end
        end
    end
endmodule

// File: tb/tb_neuron_input_layer.sv
// tb_neuron_input_layer: table-driven check of the neuron with its step counter
module tb_neuron_input_layer;
    localparam int NW = 10;
    localparam int NB = 15;
    localparam int BB = 15;

    typedef struct {
        int    d [NW];
        int    w [NW];
        int    bias;
        bit    relu;
        int    exp;
        string name;
    } vec_t;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                activation_function = 1'b0;
    logic signed [31:0]  weights [0:NW];
    logic signed [NB:0]  data_in [0:NW];
    logic signed [BB:0]  b = '0;
    logic [31:0]         counter_out;
    logic                counter_donestatus;
    logic signed [NB+8:0] data_out;

    int checks = 0;
    int errors = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    counter #(.END_COUNTER(NW - 1)) u_cnt (
        .clk(clk), .rstn(rstn), .counter_out(counter_out), .counter_donestatus(counter_donestatus)
    );

    neuron_input_layer #(.NEURON_WIDTH(NW), .NEURON_BITS(NB), .B_BITS(BB)) dut (
        .clk(clk), .rstn(rstn), .activation_function(activation_function), .weights(weights),
        .data_in(data_in), .b(b), .counter(counter_out), .data_out(data_out)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < NW; i++) begin
            data_in[i] = 16'(v.d[i]);
            weights[i] = v.w[i];
        end
        data_in[NW] = 16'sh7fff;
        weights[NW] = 32'sh7fffffff;
        b = 16'(v.bias);
        activation_function = v.relu;
    endtask

    task automatic start();
        @(negedge clk) rstn = 1'b0;
        @(negedge clk);
        check("reset data_out", data_out, 0);
        check("reset counter", counter_out, 0);
        rstn = 1'b1;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 40; n++) begin
            if (counter_donestatus) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL done timeout: got counter_donestatus=0 expected 1 within 40 cycles");
    endtask

    initial begin
        for (int i = 0; i <= NW; i++) begin
            weights[i] = '0;
            data_in[i] = '0;
        end
        vecs[0] = '{d: '{-2,5,-1,10,3,-4,7,-6,2,8}, w: '{3,2,8,10,1,2,4,3,5,2}, bias: 5, relu: 1, exp: 132, name: "mixed"};
        vecs[1] = '{d: '{2,3,4,1,5,2,3,4,1,2}, w: '{5,6,7,2,3,4,5,6,1,2}, bias: 10, relu: 1, exp: 135, name: "positive"};
        vecs[2] = '{d: '{50,100,75,25,60,80,90,40,30,70}, w: '{10,20,15,5,12,18,25,8,7,14}, bias: 50, relu: 1, exp: 9720, name: "large"};
        vecs[3] = '{d: '{default: -1}, w: '{default: 1}, bias: 0, relu: 1, exp: 0, name: "neg relu"};
        vecs[4] = '{d: '{default: -1}, w: '{default: 1}, bias: 0, relu: 0, exp: -10, name: "neg identity"};
        vecs[5] = '{d: '{default: 32767}, w: '{default: 32'h7fffffff}, bias: 0, relu: 1, exp: 8388607, name: "sat high"};
        vecs[6] = '{d: '{default: -32768}, w: '{default: 32'h7fffffff}, bias: 0, relu: 0, exp: -8388608, name: "sat low"};
        vecs[7] = '{d: '{default: 0}, w: '{default: 3}, bias: -5, relu: 0, exp: -5, name: "bias only"};

        for (int k = 0; k < 8; k++) begin
            load(vecs[k]);
            start();
            wait_done();
            repeat (5) @(negedge clk);
            check(vecs[k].name, data_out, vecs[k].exp);
        end

        load(vecs[1]);
        start();
        wait_done();
        check("latency counter at end", counter_out, NW - 1);
        check("latency edge0", data_out, 0);
        @(negedge clk);
        check("latency edge1", data_out, 0);
        @(negedge clk);
        check("latency edge2", data_out, 135);

        load(vecs[2]);
        start();
        for (int n = 0; n < 20 && counter_out != 4; n++) @(negedge clk);
        check("mid-run counter", counter_out, 4);
        rstn = 1'b0;
        #1;
        check("async reset data_out", data_out, 0);
        check("async reset counter", counter_out, 0);
        check("async reset done", counter_donestatus, 0);
        load(vecs[1]);
        @(negedge clk) rstn = 1'b1;
        wait_done();
        repeat (2) @(negedge clk);
        check("restart result", data_out, 135);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            check("hold data_out", data_out, 135);
            check("hold counter", counter_out, NW - 1);
            check("hold done", counter_donestatus, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
